audio_level_meter: RTL and testbench

Peak-level and clip meter sitting directly downstream of the audio gain stage: it consumes each post-gain 16-bit signed sample, tracks a peak envelope with programmable hold and exponential-style decay, and counts full-scale (clipped) samples. Results are exposed through the same 8-bit SPI register-access style as the gain block (rd_en/wr_en/data_in/data_out), plus an optional clip interrupt.

---
 rtl/audio_pkg.sv | 24 ++
 rtl/audio_level_meter_regs.sv | 101 ++++++++++
 rtl/audio_level_meter.sv | 110 +++++++++++
 tb/tb_audio_level_meter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio level meter: FSM states, register
// addresses, full-scale sample values and CTRL bit positions.
package audio_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } meter_state_e;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PEAK    = 2'd1;
    localparam logic [1:0] ADDR_CLIPCNT = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam logic signed [15:0] FULL_SCALE_POS = 16'sh7FFF;
    localparam logic signed [15:0] FULL_SCALE_NEG = 16'sh8000;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;
    localparam int CTRL_IRQ_BIT = 2;
    localparam int STAT_CLIP_BIT = 0;

endpackage

// File: rtl/audio_level_meter_regs.sv
// Register file for the level meter: CTRL, clip counter, sticky clip flag,
// registered read mux and interrupt output.
module audio_level_meter_regs
    import audio_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  addr_i,
    input  logic        wr_en_i,
    input  logic        rd_en_i,
    input  logic [7:0]  data_in_i,
    input  logic [14:0] peak_i,
    input  logic        in_hold_i,
    input  logic        clip_evt_i,
    output logic        enable_o,
    output logic        clear_o,
    output logic        clear_en_o,
    output logic [7:0]  data_out_o,
    output logic        clip_irq_o
);

    logic       enable_q, enable_d;
    logic       irq_en_q, irq_en_d;
    logic [7:0] clipcnt_q, clipcnt_d;
    logic       sticky_q, sticky_d;
    logic [7:0] data_out_q, data_out_d;
    logic       clip_irq_q;

    logic wr_ctrl, wr_stat, rd_cnt;

    assign wr_ctrl    = wr_en_i && (addr_i == ADDR_CTRL);
    assign wr_stat    = wr_en_i && (addr_i == ADDR_STATUS);
    assign rd_cnt     = rd_en_i && (addr_i == ADDR_CLIPCNT);
    assign clear_o    = wr_ctrl && data_in_i[CTRL_CLR_BIT];
    assign clear_en_o = data_in_i[CTRL_EN_BIT];

    always_comb begin
        enable_d = enable_q;
        irq_en_d = irq_en_q;
        if (wr_ctrl) begin
            enable_d = data_in_i[CTRL_EN_BIT];
            irq_en_d = data_in_i[CTRL_IRQ_BIT];
        end
    end

    // Read-clear and a same-cycle clip leave the counter at 1, not 0.
    always_comb begin
        clipcnt_d = clipcnt_q;
        if (clear_o)
            clipcnt_d = 8'd0;
        else if (rd_cnt)
            clipcnt_d = clip_evt_i ? 8'd1 : 8'd0;
        else if (clip_evt_i && clipcnt_q != 8'hFF)
            clipcnt_d = clipcnt_q + 8'd1;
    end

    always_comb begin
        sticky_d = sticky_q;
        if (clear_o)
            sticky_d = 1'b0;
        else if (clip_evt_i)
            sticky_d = 1'b1;
        else if (wr_stat && data_in_i[STAT_CLIP_BIT])
            sticky_d = 1'b0;
    end

    always_comb begin
        data_out_d = 8'd0;
        if (rd_en_i) begin
            case (addr_i)
                ADDR_CTRL:    data_out_d = {5'd0, irq_en_q, 1'b0, enable_q};
                ADDR_PEAK:    data_out_d = peak_i[14:7];
                ADDR_CLIPCNT: data_out_d = clipcnt_q;
                default:      data_out_d = {6'd0, in_hold_i, sticky_q};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            clipcnt_q  <= 8'd0;
            sticky_q   <= 1'b0;
            data_out_q <= 8'd0;
            clip_irq_q <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            clipcnt_q  <= clipcnt_d;
            sticky_q   <= sticky_d;
            data_out_q <= data_out_d;
            clip_irq_q <= irq_en_q & sticky_q;
        end
    end

    assign enable_o   = enable_q;
    assign data_out_o = data_out_q;
    assign clip_irq_o = clip_irq_q;

endmodule

// File: rtl/audio_level_meter.sv
// Peak envelope (hold + proportional decay) and clip meter for post-gain
// samples, with a small register interface.
module audio_level_meter
    import audio_pkg::*;
#(
    parameter int HOLD_SAMPLES = 4800,
    parameter int DECAY_SHIFT  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] x_in,
    input  logic        x_valid,
    input  logic [1:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        clip_irq
);

    meter_state_e state_q, state_d, cur_state;
    logic [14:0]  peak_q, peak_d;
    logic [15:0]  hold_q, hold_d;

    logic        enable, clear, clear_en, clip_evt, in_hold;
    logic [15:0] neg_x;
    logic [14:0] mag, step, peak_dec;

    // -32768 has no positive 15-bit twin; pin it to full scale.
    assign neg_x = ~x_in + 16'd1;
    always_comb begin
        if (x_in == FULL_SCALE_NEG)
            mag = 15'h7FFF;
        else if (x_in[15])
            mag = neg_x[14:0];
        else
            mag = x_in[14:0];
    end

    assign step     = (peak_q >> DECAY_SHIFT) + 15'd1;
    assign peak_dec = (peak_q > step) ? (peak_q - step) : 15'd0;

    assign clip_evt = x_valid && enable &&
                      ((x_in == FULL_SCALE_POS) || (x_in == FULL_SCALE_NEG));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= OFF;
            peak_q  <= 15'd0;
            hold_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            peak_q  <= peak_d;
            hold_q  <= hold_d;
        end
    end

    // The first enabled cycle after OFF behaves as DECAY so no sample is lost.
    always_comb begin
        state_d   = state_q;
        peak_d    = peak_q;
        hold_d    = hold_q;
        cur_state = (state_q == OFF) ? DECAY : state_q;
        if (clear) begin
            peak_d  = 15'd0;
            hold_d  = 16'd0;
            state_d = clear_en ? DECAY : OFF;
        end else if (!enable) begin
            state_d = OFF;
        end else begin
            state_d = cur_state;
            if (x_valid) begin
                if (mag > peak_q) begin
                    peak_d  = mag;
                    hold_d  = 16'(HOLD_SAMPLES - 1);
                    state_d = HOLD;
                end else if (cur_state == HOLD) begin
                    if (hold_q == 16'd0)
                        state_d = DECAY;
                    else
                        hold_d = hold_q - 16'd1;
                end else begin
                    peak_d = peak_dec;
                end
            end
        end
    end

    always_comb begin
        in_hold = (state_q == HOLD);
    end

    audio_level_meter_regs u_regs (
        .clk        (clk),
        .reset_n    (reset_n),
        .addr_i     (addr),
        .wr_en_i    (wr_en),
        .rd_en_i    (rd_en),
        .data_in_i  (data_in),
        .peak_i     (peak_q),
        .in_hold_i  (in_hold),
        .clip_evt_i (clip_evt),
        .enable_o   (enable),
        .clear_o    (clear),
        .clear_en_o (clear_en),
        .data_out_o (data_out),
        .clip_irq_o (clip_irq)
    );

endmodule

// File: tb/tb_audio_level_meter.sv
// Directed-vector bench for audio_level_meter (HOLD_SAMPLES=4, DECAY_SHIFT=4).
module tb_audio_level_meter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] x_in;
    logic        x_valid;
    logic [1:0]  addr;
    logic        wr_en, rd_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        clip_irq;

    int total = 0;
    int bad   = 0;

    audio_level_meter #(.HOLD_SAMPLES(4), .DECAY_SHIFT(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .x_in     (x_in),
        .x_valid  (x_valid),
        .addr     (addr),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .clip_irq (clip_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        addr = a; data_in = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; data_in = 8'd0;
    endtask

    task automatic rd(input logic [1:0] a);
        addr = a; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic samp(input logic [15:0] x);
        x_in = x; x_valid = 1'b1;
        tick();
        x_valid = 1'b0; x_in = 16'd0;
    endtask

    initial begin
        logic [7:0] last;
        reset_n = 1'b0; x_in = 16'd0; x_valid = 1'b0;
        addr = 2'd0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'd0;
        tick(); tick();
        reset_n = 1'b1;

        // reset state
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            chk($sformatf("rst_rd%0d", a), {8'd0, data_out}, 16'h00);
        end
        chk("rst_irq", {15'd0, clip_irq}, 16'd0);

        // peak capture, hold, decay to zero
        wr(2'd0, 8'h01);
        samp(16'd16384);
        rd(2'd1);   chk("peak_16384", {8'd0, data_out}, 16'h80);
        tick();     chk("rd_idle_zero", {8'd0, data_out}, 16'h00);
        rd(2'd3);   chk("stat_hold", {8'd0, data_out}, 16'h02);
        for (int i = 0; i < 4; i++) samp(16'd0);
        rd(2'd3);   chk("stat_after_hold", {8'd0, data_out}, 16'h00);
        rd(2'd1);   chk("peak_after_hold", {8'd0, data_out}, 16'h80);
        last = 8'hFF;
        for (int i = 0; i < 400 && last != 8'h00; i++) begin
            samp(16'd0);
            rd(2'd1);
            last = data_out;
        end
        chk("decay_to_zero", {8'd0, last}, 16'h00);

        // exact hold length and decay steps
        wr(2'd0, 8'h03);
        chk("clr_peak", {1'b0, dut.peak_q}, 16'd0);
        samp(16'd1000);
        for (int i = 0; i < 4; i++) begin
            samp(16'd0);
            chk($sformatf("hold_peak%0d", i), {1'b0, dut.peak_q}, 16'd1000);
        end
        samp(16'd0); chk("decay1", {1'b0, dut.peak_q}, 16'd937);
        samp(16'd0); chk("decay2", {1'b0, dut.peak_q}, 16'd878);

        // clipping, interrupt, counter saturation
        wr(2'd0, 8'h07);
        samp(16'h8000);
        chk("irq_lag", {15'd0, clip_irq}, 16'd0);
        tick();
        chk("irq_set", {15'd0, clip_irq}, 16'd1);
        rd(2'd1);   chk("peak_fs", {8'd0, data_out}, 16'hFF);
        rd(2'd2);   chk("clipcnt1", {8'd0, data_out}, 16'd1);
        for (int i = 0; i < 300; i++) samp(16'h8000);
        rd(2'd2);   chk("clipcnt_sat", {8'd0, data_out}, 16'd255);
        rd(2'd2);   chk("clipcnt_rdclr", {8'd0, data_out}, 16'd0);

        // read-clear and W1C racing a clip sample
        samp(16'h7FFF); samp(16'h7FFF);
        addr = 2'd2; rd_en = 1'b1; x_in = 16'h7FFF; x_valid = 1'b1;
        tick();
        rd_en = 1'b0; x_valid = 1'b0;
        chk("cnt_race_old", {8'd0, data_out}, 16'd2);
        rd(2'd2);   chk("cnt_race_new", {8'd0, data_out}, 16'd1);
        addr = 2'd3; wr_en = 1'b1; data_in = 8'h01; x_in = 16'h7FFF; x_valid = 1'b1;
        tick();
        wr_en = 1'b0; x_valid = 1'b0;
        rd(2'd3);   chk("w1c_race", {15'd0, data_out[0]}, 16'd1);
        wr(2'd3, 8'h01);
        rd(2'd3);   chk("w1c_clear", {15'd0, data_out[0]}, 16'd0);
        tick();
        chk("irq_drop", {15'd0, clip_irq}, 16'd0);

        // disabled: no tracking, no counting
        wr(2'd0, 8'h03);
        wr(2'd0, 8'h00);
        samp(16'h7FFF);
        rd(2'd1);   chk("off_peak", {8'd0, data_out}, 16'h00);
        rd(2'd2);   chk("off_cnt", {8'd0, data_out}, 16'h00);

        // clear during HOLD, concurrent write/read
        wr(2'd0, 8'h01);
        samp(16'd20000);
        rd(2'd1);   chk("peak_20000", {8'd0, data_out}, 16'h9C);
        wr(2'd0, 8'h03);
        rd(2'd1);   chk("clr_hold_peak", {8'd0, data_out}, 16'h00);
        rd(2'd0);   chk("ctrl_clr_rd0", {8'd0, data_out}, 16'h01);
        addr = 2'd0; wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h05;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("wr_rd_old", {8'd0, data_out}, 16'h01);
        rd(2'd0);   chk("wr_rd_new", {8'd0, data_out}, 16'h05);

        // reset mid-HOLD
        samp(16'd20000);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        rd(2'd3);   chk("rst2_stat", {8'd0, data_out}, 16'h00);
        rd(2'd1);   chk("rst2_peak", {8'd0, data_out}, 16'h00);
        rd(2'd0);   chk("rst2_ctrl", {8'd0, data_out}, 16'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
